bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Shares the single Bridge data bus between two masters: M0 = CPU load/store port, M1 = DMA/debug master.
//  Sits between myCPU's data interface and the Bridge. Serialises accesses, holds each for a fixed slave
//  access time, returns read data with a one-cycle ack, and raises a stall to the CPU while it waits.
// PARAMETERS
//  ADDR_W      32  address width, both masters and Bridge
//  DATA_W      32  data width
//  ACC_CYC     2   cycles Bus_* are held per access (>=1); Bus_rdata is sampled in the last of them
//  FIXED_PRIO  0   0 = round-robin between M0/M1; 1 = M0 always wins on a tie
// PORTS
//  cpu_clk     in   1       clock, all state updates on rising edge
//  cpu_rst     in   1       reset, asynchronous, active-high
//  m0_req      in   1       M0 access request; held high with stable addr/wen/wdata until m0_ack
//  m0_addr     in   ADDR_W  M0 byte address
//  m0_wen      in   1       M0 write (1) / read (0)
//  m0_wdata    in   DATA_W  M0 write data
//  m0_rdata    out  DATA_W  M0 read data, valid in the m0_ack cycle, held until next M0 completion
//  m0_ack      out  1       one-cycle pulse: M0 access complete
//  m0_stall    out  1       m0_req & ~m0_ack (combinational); freezes CPU PC/pipeline
//  m1_req      in   1       M1 request, same rules as M0
//  m1_addr     in   ADDR_W  M1 byte address
//  m1_wen      in   1       M1 write / read
//  m1_wdata    in   DATA_W  M1 write data
//  m1_rdata    out  DATA_W  M1 read data, same rules as m0_rdata
//  m1_ack      out  1       one-cycle pulse: M1 access complete
//  Bus_addr    out  ADDR_W  to Bridge: address of the granted access
//  Bus_wen     out  1       to Bridge: write strobe
//  Bus_wdata   out  DATA_W  to Bridge: write data
//  Bus_rdata   in   DATA_W  from Bridge: read data
//  busy        out  1       1 while in BUSY state (status)
// BEHAVIOUR
//  Reset (async, cpu_rst=1): state=IDLE, cnt=0, last_gnt=M1 (so M0 wins the first tie), all outputs 0
//   (Bus_addr/Bus_wen/Bus_wdata/mN_rdata/mN_ack/busy). Reset mid-access aborts it: no ack, no further strobe.
//  FSM: IDLE, BUSY.
//  IDLE: Bus_* driven 0. If any req: select winner, latch its addr/wen/wdata and id into regs, cnt<=0, ->BUSY.
//   Arbitration: one req -> that master. Both: FIXED_PRIO=1 -> M0; else the master != last_gnt.
//   last_gnt updated at grant.
//  BUSY: Bus_addr/Bus_wdata driven from latched regs for all ACC_CYC cycles; Bus_wen = latched wen
//   only while cnt==0 (exactly one write strobe per access). cnt increments each cycle.
//   When cnt==ACC_CYC-1: registered ack for winner asserts next cycle together with rdata
//   <= Bus_rdata (reads only; writes leave mN_rdata unchanged); state ->IDLE.
//  Timing: req seen in IDLE at edge k -> BUSY cycles k+1..k+ACC_CYC -> ack high in cycle k+ACC_CYC+1,
//   which is an IDLE cycle; the ack cycle does not start a new grant for the acked master even if its
//   req is still high (req is sampled again only on the following edge). Other master may be granted there.
//  Minimum spacing between accesses from one master: ACC_CYC+2 cycles; bus idle >=1 cycle between accesses.
//  Req dropped while BUSY: access still completes, ack still pulses (no abort). Req changes on the
//   latched fields while BUSY are ignored.
//  At most one of m0_ack/m1_ack high in any cycle. No starvation: round-robin alternates under
//   continuous contention; FIXED_PRIO=1 may starve M1 by design.
//  busy = (state==BUSY). m0_stall is combinational from m0_req and m0_ack only.
// TESTING
//  1 M0 read, ACC_CYC=2, Bridge returns 0xDEAD_BEEF at 0x8010_0000 -> Bus_addr=0x8010_0000 for 2 cycles,
//    Bus_wen=0, m0_ack one cycle later with m0_rdata=0xDEAD_BEEF, m0_stall low in ack cycle.
//  2 M1 write 0x1234_5678 to 0xFFFF_F000 -> Bus_wen high exactly 1 cycle, Bus_wdata stable 2 cycles,
//    m1_ack pulse, m1_rdata unchanged.
//  3 m0_req and m1_req rise together, held 4 accesses, FIXED_PRIO=0 -> grant order M0,M1,M0,M1;
//    FIXED_PRIO=1 -> M0,M0,M0,M0, M1 never acked while m0_req held.
//  4 M0 granted, m0_req dropped in 1st BUSY cycle -> access completes, m0_ack still pulses, no new grant.
//  5 cpu_rst asserted in 2nd BUSY cycle (async, between edges) -> outputs 0 immediately, no ack after
//    release; next tie goes to M0.
//  6 ACC_CYC=1 sweep, 100 random mixed reads/writes on both masters vs. scoreboard memory model ->
//    all rdata match, never two acks in one cycle, Bus_wen width always 1 cycle.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Two-master request/ack handshake plus the Bridge-side bus, shared by bus_arbiter and its masters.
interface bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic [ADDR_W-1:0] m0_addr;
  logic              m0_wen;
  logic [DATA_W-1:0] m0_wdata;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_ack;
  logic              m0_stall;

  logic              m1_req;
  logic [ADDR_W-1:0] m1_addr;
  logic              m1_wen;
  logic [DATA_W-1:0] m1_wdata;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_ack;

  logic [ADDR_W-1:0] Bus_addr;
  logic              Bus_wen;
  logic [DATA_W-1:0] Bus_wdata;
  logic [DATA_W-1:0] Bus_rdata;
  logic              busy;

  modport master (
    output m0_req, m0_addr, m0_wen, m0_wdata,
    output m1_req, m1_addr, m1_wen, m1_wdata,
    output Bus_rdata,
    input  m0_rdata, m0_ack, m0_stall, m1_rdata, m1_ack,
    input  Bus_addr, Bus_wen, Bus_wdata, busy
  );

  modport slave (
    input  m0_req, m0_addr, m0_wen, m0_wdata,
    input  m1_req, m1_addr, m1_wen, m1_wdata,
    input  Bus_rdata,
    output m0_rdata, m0_ack, m0_stall, m1_rdata, m1_ack,
    output Bus_addr, Bus_wen, Bus_wdata, busy
  );
endinterface

// File: rtl/bus_arbiter.sv
// Serialises CPU (M0) and DMA/debug (M1) accesses onto the single Bridge bus.
// state | meaning
// IDLE  | bus driven 0; grant a pending request (acked master is masked for this cycle)
// BUSY  | latched access on Bus_* for ACC_CYC cycles; read data captured in the last one
module bus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int ACC_CYC    = 2,
  parameter int FIXED_PRIO = 0
) (
  input  logic cpu_clk,
  input  logic cpu_rst,
  bus_arbiter_if.slave bus
);

  localparam int CNT_W = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_CYC - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              last_gnt;
  logic              gnt_id;
  logic              lat_wen;
  logic [ADDR_W-1:0] bus_addr_q;
  logic              bus_wen_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic [DATA_W-1:0] m0_rdata_q;
  logic [DATA_W-1:0] m1_rdata_q;
  logic              m0_ack_q;
  logic              m1_ack_q;
  logic              req0_ok;
  logic              req1_ok;
  logic              win;

  // In fixed-priority mode a raised m0_req blocks M1 even during M0's ack cycle.
  always_comb begin
    req0_ok = bus.m0_req & ~m0_ack_q;
    req1_ok = bus.m1_req & ~m1_ack_q;
    if (FIXED_PRIO != 0) req1_ok = req1_ok & ~bus.m0_req;
    if (req0_ok && req1_ok) win = ~last_gnt;
    else                    win = req1_ok;
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      last_gnt    <= 1'b1;
      gnt_id      <= 1'b0;
      lat_wen     <= 1'b0;
      bus_addr_q  <= '0;
      bus_wen_q   <= 1'b0;
      bus_wdata_q <= '0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
    end else begin
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req0_ok || req1_ok) begin
            state       <= BUSY;
            cnt         <= '0;
            gnt_id      <= win;
            last_gnt    <= win;
            lat_wen     <= win ? bus.m1_wen : bus.m0_wen;
            bus_addr_q  <= win ? bus.m1_addr : bus.m0_addr;
            bus_wen_q   <= win ? bus.m1_wen : bus.m0_wen;
            bus_wdata_q <= win ? bus.m1_wdata : bus.m0_wdata;
          end
        end
        BUSY: begin
          cnt       <= cnt + 1'b1;
          bus_wen_q <= 1'b0;
          if (cnt == CNT_LAST) begin
            state       <= IDLE;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if (gnt_id) begin
              m1_ack_q <= 1'b1;
              if (!lat_wen) m1_rdata_q <= bus.Bus_rdata;
            end else begin
              m0_ack_q <= 1'b1;
              if (!lat_wen) m0_rdata_q <= bus.Bus_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Bus_addr  = bus_addr_q;
  assign bus.Bus_wen   = bus_wen_q;
  assign bus.Bus_wdata = bus_wdata_q;
  assign bus.m0_rdata  = m0_rdata_q;
  assign bus.m1_rdata  = m1_rdata_q;
  assign bus.m0_ack    = m0_ack_q;
  assign bus.m1_ack    = m1_ack_q;
  assign bus.m0_stall  = bus.m0_req & ~m0_ack_q;
  assign bus.busy      = (state == BUSY);

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: cycle table on a round-robin ACC_CYC=2 instance, contention on a
// fixed-priority twin, reset abort, and a random ACC_CYC=1 run against a memory scoreboard.
module tb_bus_arbiter;

  logic clk;
  logic rst;

  bus_arbiter_if bus0 ();
  bus_arbiter_if bus1 ();
  bus_arbiter_if bus2 ();

  bus_arbiter #(.ACC_CYC(2), .FIXED_PRIO(0)) u_dut0 (.cpu_clk(clk), .cpu_rst(rst), .bus(bus0));
  bus_arbiter #(.ACC_CYC(2), .FIXED_PRIO(1)) u_dut1 (.cpu_clk(clk), .cpu_rst(rst), .bus(bus1));
  bus_arbiter #(.ACC_CYC(1), .FIXED_PRIO(0)) u_dut2 (.cpu_clk(clk), .cpu_rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        m0_req;
    logic [31:0] m0_addr;
    logic        m0_wen;
    logic [31:0] m0_wdata;
    logic        m1_req;
    logic [31:0] m1_addr;
    logic        m1_wen;
    logic [31:0] m1_wdata;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic        e_wen;
    logic [31:0] e_wdata;
    logic        e_ack0;
    logic        e_ack1;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic        e_busy;
    logic        e_stall;
  } vec_t;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [31:0] Z  = 32'h0000_0000;
  localparam logic [31:0] A0 = 32'h8010_0000;
  localparam logic [31:0] D0 = 32'hDEAD_BEEF;
  localparam logic [31:0] A1 = 32'hFFFF_F000;
  localparam logic [31:0] W1 = 32'h1234_5678;
  localparam logic [31:0] X1 = 32'hAAAA_5555;
  localparam logic [31:0] R1 = 32'h0000_0040;
  localparam logic [31:0] R2 = 32'h0000_0080;

  vec_t        vecs [15];
  int          n_checks;
  int          n_errors;
  int          q0[$];
  int          q1[$];
  int          m1_seen1;
  int          n_done;
  int          first_ack;
  logic        d0;
  logic        d1;
  logic        prev_wen;
  logic [31:0] bmem    [16];
  logic [31:0] ref_mem [16];

  // Bridge model for the random run: combinational read, write on the strobe edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) bmem[i] <= {4{8'(i)}};
    end else if (bus2.Bus_wen) begin
      bmem[bus2.Bus_addr[5:2]] <= bus2.Bus_wdata;
    end
  end
  assign bus2.Bus_rdata = bmem[bus2.Bus_addr[5:2]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_access(input int id, input logic wen, input logic [3:0] idx, input logic [31:0] wd);
    logic got;
    got = 1'b0;
    if (id == 0) begin
      bus2.m0_addr = {26'd0, idx, 2'b00}; bus2.m0_wen = wen; bus2.m0_wdata = wd; bus2.m0_req = 1'b1;
    end else begin
      bus2.m1_addr = {26'd0, idx, 2'b00}; bus2.m1_wen = wen; bus2.m1_wdata = wd; bus2.m1_req = 1'b1;
    end
    for (int t = 0; t < 40 && !got; t++) begin
      tick();
      got = (id == 0) ? bus2.m0_ack : bus2.m1_ack;
    end
    chk($sformatf("rand_m%0d_ack_seen", id), 32'(got), 32'd1);
    if (got) begin
      n_done++;
      if (wen) ref_mem[idx] = wd;
      else chk($sformatf("rand_m%0d_rdata", id), (id == 0) ? bus2.m0_rdata : bus2.m1_rdata, ref_mem[idx]);
    end
    if (id == 0) bus2.m0_req = 1'b0;
    else         bus2.m1_req = 1'b0;
  endtask

  task automatic master_run(input int id, input int n);
    for (int k = 0; k < n; k++) begin
      do_access(id, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_errors = 0; n_done = 0; m1_seen1 = 0;
    rst = 1'b1;
    bus0.m0_req = 0; bus0.m0_addr = 0; bus0.m0_wen = 0; bus0.m0_wdata = 0;
    bus0.m1_req = 0; bus0.m1_addr = 0; bus0.m1_wen = 0; bus0.m1_wdata = 0; bus0.Bus_rdata = 0;
    bus1.m0_req = 0; bus1.m0_addr = 0; bus1.m0_wen = 0; bus1.m0_wdata = 0;
    bus1.m1_req = 0; bus1.m1_addr = 0; bus1.m1_wen = 0; bus1.m1_wdata = 0; bus1.Bus_rdata = 0;
    bus2.m0_req = 0; bus2.m0_addr = 0; bus2.m0_wen = 0; bus2.m0_wdata = 0;
    bus2.m1_req = 0; bus2.m1_addr = 0; bus2.m1_wen = 0; bus2.m1_wdata = 0;

    vecs[0]  = '{H, A0, L, Z, L, Z,  L, Z,  D0, Z,  L, Z,  L, L, Z,  Z,  L, H};
    vecs[1]  = '{H, A0, L, Z, L, Z,  L, Z,  D0, A0, L, Z,  L, L, Z,  Z,  H, H};
    vecs[2]  = '{H, A0, L, Z, L, Z,  L, Z,  D0, A0, L, Z,  L, L, Z,  Z,  H, H};
    vecs[3]  = '{H, A0, L, Z, L, Z,  L, Z,  D0, Z,  L, Z,  H, L, D0, Z,  L, L};
    vecs[4]  = '{L, A0, L, Z, L, Z,  L, Z,  D0, Z,  L, Z,  L, L, D0, Z,  L, L};
    vecs[5]  = '{L, Z,  L, Z, H, A1, H, W1, X1, Z,  L, Z,  L, L, D0, Z,  L, L};
    vecs[6]  = '{L, Z,  L, Z, H, A1, H, W1, X1, A1, H, W1, L, L, D0, Z,  H, L};
    vecs[7]  = '{L, Z,  L, Z, H, A1, H, W1, X1, A1, L, W1, L, L, D0, Z,  H, L};
    vecs[8]  = '{L, Z,  L, Z, H, A1, H, W1, X1, Z,  L, Z,  L, H, D0, Z,  L, L};
    vecs[9]  = '{L, Z,  L, Z, L, A1, H, W1, X1, Z,  L, Z,  L, L, D0, Z,  L, L};
    vecs[10] = '{L, Z,  L, Z, H, R1, L, Z,  X1, Z,  L, Z,  L, L, D0, Z,  L, L};
    vecs[11] = '{L, Z,  L, Z, H, R2, H, W1, X1, R1, L, Z,  L, L, D0, Z,  H, L};
    vecs[12] = '{L, Z,  L, Z, H, R2, H, W1, X1, R1, L, Z,  L, L, D0, Z,  H, L};
    vecs[13] = '{L, Z,  L, Z, H, R2, H, W1, X1, Z,  L, Z,  L, H, D0, X1, L, L};
    vecs[14] = '{L, Z,  L, Z, L, Z,  L, Z,  X1, Z,  L, Z,  L, L, D0, X1, L, L};

    // Reset state on every instance
    repeat (2) @(posedge clk);
    #1;
    chk("rst0_bus_addr", bus0.Bus_addr, 0);
    chk("rst0_busy", 32'(bus0.busy), 0);
    chk("rst0_acks", 32'({bus0.m0_ack, bus0.m1_ack}), 0);
    chk("rst1_busy", 32'(bus1.busy), 0);
    chk("rst2_bus_wen", 32'(bus2.Bus_wen), 0);
    rst = 1'b0;
    tick();

    // Tests 1-2 and an M1 read with fields changed mid-access
    for (int i = 0; i < 15; i++) begin
      bus0.m0_req = vecs[i].m0_req; bus0.m0_addr = vecs[i].m0_addr;
      bus0.m0_wen = vecs[i].m0_wen; bus0.m0_wdata = vecs[i].m0_wdata;
      bus0.m1_req = vecs[i].m1_req; bus0.m1_addr = vecs[i].m1_addr;
      bus0.m1_wen = vecs[i].m1_wen; bus0.m1_wdata = vecs[i].m1_wdata;
      bus0.Bus_rdata = vecs[i].rdata;
      #1;
      chk($sformatf("v%0d_bus_addr", i), bus0.Bus_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_bus_wen", i), 32'(bus0.Bus_wen), 32'(vecs[i].e_wen));
      chk($sformatf("v%0d_bus_wdata", i), bus0.Bus_wdata, vecs[i].e_wdata);
      chk($sformatf("v%0d_m0_ack", i), 32'(bus0.m0_ack), 32'(vecs[i].e_ack0));
      chk($sformatf("v%0d_m1_ack", i), 32'(bus0.m1_ack), 32'(vecs[i].e_ack1));
      chk($sformatf("v%0d_m0_rdata", i), bus0.m0_rdata, vecs[i].e_rd0);
      chk($sformatf("v%0d_m1_rdata", i), bus0.m1_rdata, vecs[i].e_rd1);
      chk($sformatf("v%0d_busy", i), 32'(bus0.busy), 32'(vecs[i].e_busy));
      chk($sformatf("v%0d_m0_stall", i), 32'(bus0.m0_stall), 32'(vecs[i].e_stall));
      tick();
    end

    // Test 3: continuous contention, round-robin vs fixed priority
    bus0.m0_req = 1; bus0.m1_req = 1; bus0.m0_wen = 0; bus0.m1_wen = 0;
    bus1.m0_req = 1; bus1.m1_req = 1;
    for (int c = 0; c < 24; c++) begin
      tick();
      chk("rr_single_ack", 32'(bus0.m0_ack & bus0.m1_ack), 0);
      if (bus0.m0_ack) q0.push_back(0);
      if (bus0.m1_ack) q0.push_back(1);
      if (bus1.m0_ack) q1.push_back(0);
      if (bus1.m1_ack) m1_seen1++;
    end
    chk("rr_ack_count_ge4", 32'(q0.size() >= 4), 1);
    chk("fp_ack_count_ge4", 32'(q1.size() >= 4), 1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr_order%0d", k), (k < q0.size()) ? 32'(q0[k]) : 32'd99, 32'(k % 2));
      chk($sformatf("fp_order%0d", k), (k < q1.size()) ? 32'(q1[k]) : 32'd99, 32'd0);
    end
    chk("fp_m1_never_acked", 32'(m1_seen1), 0);
    bus0.m0_req = 0; bus0.m1_req = 0; bus1.m0_req = 0; bus1.m1_req = 0;
    repeat (6) tick();

    // Test 4: request dropped in the first BUSY cycle
    bus0.m0_req = 1; bus0.m0_addr = 32'h10; bus0.m0_wen = 0; bus0.Bus_rdata = 32'h0BAD_F00D;
    tick();
    bus0.m0_req = 0;
    #1;
    chk("drop_busy1", 32'(bus0.busy), 1);
    chk("drop_stall", 32'(bus0.m0_stall), 0);
    tick();
    chk("drop_busy2", 32'(bus0.busy), 1);
    tick();
    chk("drop_ack", 32'(bus0.m0_ack), 1);
    chk("drop_rdata", bus0.m0_rdata, 32'h0BAD_F00D);
    tick();
    chk("drop_ack_pulse", 32'(bus0.m0_ack), 0);
    tick();
    chk("drop_no_regrant", 32'(bus0.busy), 0);

    // Test 5: async reset in the second BUSY cycle
    bus0.m0_req = 1; bus0.m0_addr = 32'h20; bus0.m0_wen = 1; bus0.m0_wdata = 32'h55;
    tick();
    chk("abort_wen_strobe", 32'(bus0.Bus_wen), 1);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("abort_bus_addr", bus0.Bus_addr, 0);
    chk("abort_bus_wdata", bus0.Bus_wdata, 0);
    chk("abort_busy", 32'(bus0.busy), 0);
    chk("abort_m0_rdata", bus0.m0_rdata, 0);
    bus0.m0_req = 0; bus0.m0_wen = 0;
    @(posedge clk);
    #4;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("abort_no_ack", 32'({bus0.m0_ack, bus0.m1_ack}), 0);
    end
    bus0.m0_req = 1; bus0.m1_req = 1;
    first_ack = -1;
    for (int c = 0; c < 12 && first_ack < 0; c++) begin
      tick();
      if (bus0.m0_ack) first_ack = 0;
      else if (bus0.m1_ack) first_ack = 1;
    end
    chk("post_rst_tie_m0", 32'(first_ack), 0);
    bus0.m0_req = 0; bus0.m1_req = 0;
    repeat (6) tick();

    // Test 6: ACC_CYC=1, random traffic on both masters
    for (int i = 0; i < 16; i++) ref_mem[i] = {4{8'(i)}};
    d0 = 0; d1 = 0; prev_wen = 0;
    fork
      begin master_run(0, 50); d0 = 1; end
      begin master_run(1, 50); d1 = 1; end
      begin
        for (int c = 0; c < 3000 && !(d0 && d1); c++) begin
          @(posedge clk);
          #1;
          chk("rand_single_ack", 32'(bus2.m0_ack & bus2.m1_ack), 0);
          if (bus2.Bus_wen) chk("rand_wen_width", 32'(prev_wen), 0);
          prev_wen = bus2.Bus_wen;
        end
      end
    join
    chk("rand_done_count", 32'(n_done), 100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
